bcd_sevenseg_scan: RTL and testbench

Four-digit, time-multiplexed seven-segment driver that consumes BCD digits produced by the decade counter stages. It captures a packed 4-digit BCD word and scans one digit per refresh slot onto a common segment bus. It drives active-low anodes and segments directly to the board display. It applies optional leading-zero blanking and shows a dash for non-BCD codes.

---
 rtl/bcd_sevenseg_scan_if.sv | 13 +
 rtl/bcd_sevenseg_scan.sv | 159 +++++++++++++++
 tb/tb_bcd_sevenseg_scan.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/bcd_sevenseg_scan_if.sv
// Display bus of the four-digit scanner: BCD word and controls in, active-low
// segment/anode drive and frame marker out.
interface bcd_sevenseg_scan_if;
  logic [15:0] bcd_in;
  logic        load;
  logic        blank_lz;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame;

  modport master (output bcd_in, load, blank_lz, input seg, an, frame);
  modport slave  (input bcd_in, load, blank_lz, output seg, an, frame);
endinterface

// File: rtl/bcd_sevenseg_scan.sv
// Time-multiplexed 4-digit seven-segment driver: shadow-registered BCD word,
// per-slot prescaler, leading-zero blanking and dash for non-BCD codes.
//
// state  | meaning
// S_DIG0 | scanning digit 0 (least significant)
// S_DIG1 | scanning digit 1
// S_DIG2 | scanning digit 2
// S_DIG3 | scanning digit 3, wraps to S_DIG0 with a frame pulse
module bcd_sevenseg_scan #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                 clk,
  input  logic                 rst,
  bcd_sevenseg_scan_if.slave   bus
);

  localparam int unsigned PW = ($clog2(REFRESH_DIV + 1) > 0) ? $clog2(REFRESH_DIV + 1) : 1;
  localparam logic [PW-1:0] TC = PW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    S_DIG0 = 2'd0,
    S_DIG1 = 2'd1,
    S_DIG2 = 2'd2,
    S_DIG3 = 2'd3
  } scan_t;

  scan_t         r_state;
  scan_t         w_state_nxt;
  logic [PW-1:0] r_presc;
  logic          w_adv;
  logic [15:0]   r_shadow;
  logic [6:0]    r_seg;
  logic [3:0]    r_an;
  logic          r_frame;
  logic [3:0]    w_digit;
  logic [3:0]    w_zero;
  logic          w_blank;
  logic [6:0]    w_dec;
  logic [6:0]    w_seg_nxt;
  logic [3:0]    w_an_nxt;

  assign w_adv = (r_presc == TC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
    end else if (w_adv) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_DIG0;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_adv) begin
      case (r_state)
        S_DIG0:  w_state_nxt = S_DIG1;
        S_DIG1:  w_state_nxt = S_DIG2;
        S_DIG2:  w_state_nxt = S_DIG3;
        S_DIG3:  w_state_nxt = S_DIG0;
        default: w_state_nxt = S_DIG0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow <= '0;
    end else if (bus.load) begin
      r_shadow <= bus.bcd_in;
    end
  end

  assign w_zero[0] = (r_shadow[3:0]   == 4'd0);
  assign w_zero[1] = (r_shadow[7:4]   == 4'd0);
  assign w_zero[2] = (r_shadow[11:8]  == 4'd0);
  assign w_zero[3] = (r_shadow[15:12] == 4'd0);

  // A digit is dark only if it and every more significant digit are zero;
  // non-BCD codes are non-zero so a dash is never blanked.
  always_comb begin
    w_digit = r_shadow[3:0];
    w_blank = 1'b0;
    case (r_state)
      S_DIG0: begin
        w_digit = r_shadow[3:0];
        w_blank = 1'b0;
      end
      S_DIG1: begin
        w_digit = r_shadow[7:4];
        w_blank = &w_zero[3:1];
      end
      S_DIG2: begin
        w_digit = r_shadow[11:8];
        w_blank = &w_zero[3:2];
      end
      S_DIG3: begin
        w_digit = r_shadow[15:12];
        w_blank = w_zero[3];
      end
      default: begin
        w_digit = r_shadow[3:0];
        w_blank = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_dec = 7'h3F;
    case (w_digit)
      4'd0:    w_dec = 7'h40;
      4'd1:    w_dec = 7'h79;
      4'd2:    w_dec = 7'h24;
      4'd3:    w_dec = 7'h30;
      4'd4:    w_dec = 7'h19;
      4'd5:    w_dec = 7'h12;
      4'd6:    w_dec = 7'h02;
      4'd7:    w_dec = 7'h78;
      4'd8:    w_dec = 7'h00;
      4'd9:    w_dec = 7'h10;
      default: w_dec = 7'h3F;
    endcase
  end

  always_comb begin
    w_seg_nxt = w_dec;
    w_an_nxt  = ~(4'b0001 << r_state);
    if (bus.blank_lz && w_blank) begin
      w_seg_nxt = 7'h7F;
      w_an_nxt  = 4'hF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg   <= 7'h7F;
      r_an    <= 4'hF;
      r_frame <= 1'b0;
    end else begin
      r_seg   <= w_seg_nxt;
      r_an    <= w_an_nxt;
      r_frame <= w_adv && (r_state == S_DIG3);
    end
  end

  assign bus.seg   = r_seg;
  assign bus.an    = r_an;
  assign bus.frame = r_frame;

endmodule

// File: tb/tb_bcd_sevenseg_scan.sv
// Directed bench for bcd_sevenseg_scan: per-edge expectations queued as
// {an, seg, frame} and compared against the selected instance.
module tb_bcd_sevenseg_scan;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bcd_sevenseg_scan_if if4 ();
  bcd_sevenseg_scan_if if1 ();

  bcd_sevenseg_scan #(.REFRESH_DIV(4)) u4 (.clk(clk), .rst(rst), .bus(if4));
  bcd_sevenseg_scan #(.REFRESH_DIV(1)) u1 (.clk(clk), .rst(rst), .bus(if1));

  int          total = 0;
  int          bad = 0;
  int          edge_n = 0;
  int          sel = 4;
  string       tag = "init";
  logic [11:0] q[$];

  function automatic logic [11:0] pk(input logic [3:0] an, input logic [6:0] seg, input logic fr);
    return {an, seg, fr};
  endfunction

  task automatic push(input logic [3:0] an, input logic [6:0] seg, input int n, input logic fr_last);
    for (int i = 0; i < n; i++) q.push_back(pk(an, seg, (i == n - 1) ? fr_last : 1'b0));
  endtask

  task automatic drive(input logic [15:0] bcd, input logic ld, input logic blz);
    if4.bcd_in = bcd; if4.load = ld; if4.blank_lz = blz;
    if1.bcd_in = bcd; if1.load = ld; if1.blank_lz = blz;
  endtask

  task automatic run(input int n);
    logic [11:0] obs;
    logic [11:0] exp;
    repeat (n) begin
      @(posedge clk);
      #1;
      edge_n++;
      obs = (sel == 4) ? pk(if4.an, if4.seg, if4.frame) : pk(if1.an, if1.seg, if1.frame);
      exp = 'x;
      if (q.size() > 0) exp = q.pop_front();
      total++;
      assert (obs === exp) else begin
        bad++;
        $error("FAIL %s edge %0d: observed an_seg_frame=%h expected=%h", tag, edge_n, obs, exp);
      end
    end
  endtask

  task automatic check_dark(input string what);
    logic [23:0] obs;
    obs = {pk(if4.an, if4.seg, if4.frame), pk(if1.an, if1.seg, if1.frame)};
    total++;
    assert (obs === {pk(4'hF, 7'h7F, 1'b0), pk(4'hF, 7'h7F, 1'b0)}) else begin
      bad++;
      $error("FAIL %s dark: observed=%h expected=%h", what, obs, {pk(4'hF, 7'h7F, 1'b0), pk(4'hF, 7'h7F, 1'b0)});
    end
  endtask

  // Asserts reset between edges, checks both instances go dark without a clock,
  // and releases it so the next posedge is edge 1 of the new run.
  task automatic do_reset(input string what);
    drive(16'h0000, 1'b0, 1'b0);
    rst = 1'b1;
    #3;
    check_dark({what, "_async"});
    @(posedge clk);
    #1;
    check_dark({what, "_held"});
    rst = 1'b0;
    edge_n = 0;
  endtask

  initial begin
    drive(16'h0000, 1'b0, 1'b0);
    #2;

    // Reset and first frames with 1234
    tag = "first_frame";
    do_reset("rst_first");
    drive(16'h1234, 1'b1, 1'b0);
    push(4'hE, 7'h40, 1, 1'b0);
    push(4'hE, 7'h19, 3, 1'b0);
    push(4'hD, 7'h30, 4, 1'b0);
    push(4'hB, 7'h24, 4, 1'b0);
    push(4'h7, 7'h79, 4, 1'b1);
    push(4'hE, 7'h19, 4, 1'b0);
    push(4'hD, 7'h30, 4, 1'b0);
    push(4'hB, 7'h24, 4, 1'b0);
    push(4'h7, 7'h79, 4, 1'b1);
    run(1);
    drive(16'h1234, 1'b0, 1'b0);
    run(31);

    // Leading-zero blanking
    tag = "lz_blank";
    do_reset("rst_lz");
    drive(16'h0005, 1'b1, 1'b1);
    push(4'hE, 7'h40, 1, 1'b0);
    push(4'hE, 7'h12, 3, 1'b0);
    push(4'hF, 7'h7F, 4, 1'b0);
    push(4'hF, 7'h7F, 4, 1'b0);
    push(4'hF, 7'h7F, 4, 1'b1);
    run(1);
    drive(16'h0005, 1'b0, 1'b1);
    run(15);
    tag = "lz_zero";
    drive(16'h0000, 1'b1, 1'b1);
    push(4'hE, 7'h12, 1, 1'b0);
    push(4'hE, 7'h40, 3, 1'b0);
    push(4'hF, 7'h7F, 4, 1'b0);
    push(4'hF, 7'h7F, 4, 1'b0);
    push(4'hF, 7'h7F, 4, 1'b1);
    run(1);
    drive(16'h0000, 1'b0, 1'b1);
    run(15);
    tag = "lz_off";
    drive(16'h0000, 1'b0, 1'b0);
    push(4'hE, 7'h40, 4, 1'b0);
    push(4'hD, 7'h40, 4, 1'b0);
    push(4'hB, 7'h40, 4, 1'b0);
    push(4'h7, 7'h40, 4, 1'b1);
    run(16);

    // Non-BCD codes with blanking enabled
    tag = "invalid";
    do_reset("rst_inv");
    drive(16'hFA90, 1'b1, 1'b1);
    push(4'hE, 7'h40, 4, 1'b0);
    push(4'hD, 7'h10, 4, 1'b0);
    push(4'hB, 7'h3F, 4, 1'b0);
    push(4'h7, 7'h3F, 4, 1'b1);
    run(1);
    drive(16'hFA90, 1'b0, 1'b1);
    run(15);

    // Load on the same edge as the 0->1 advance
    tag = "collide";
    do_reset("rst_col");
    push(4'hE, 7'h40, 4, 1'b0);
    run(3);
    drive(16'h8888, 1'b1, 1'b0);
    run(1);
    drive(16'h8888, 1'b0, 1'b0);
    push(4'hD, 7'h00, 4, 1'b0);
    push(4'hB, 7'h00, 4, 1'b0);
    push(4'h7, 7'h00, 4, 1'b1);
    run(12);
    push(4'hE, 7'h00, 4, 1'b0);
    push(4'hD, 7'h00, 4, 1'b0);
    push(4'hB, 7'h00, 1, 1'b0);
    run(9);

    // Async reset in the middle of slot 2; shadow is cleared, slot 0 full length
    tag = "mid_reset";
    do_reset("rst_mid");
    push(4'hE, 7'h40, 4, 1'b0);
    push(4'hD, 7'h40, 1, 1'b0);
    run(5);

    // REFRESH_DIV=1 instance: one slot per edge
    tag = "div1";
    do_reset("rst_div1");
    sel = 1;
    drive(16'h4321, 1'b1, 1'b0);
    push(4'hE, 7'h40, 1, 1'b0);
    push(4'hD, 7'h24, 1, 1'b0);
    push(4'hB, 7'h30, 1, 1'b0);
    push(4'h7, 7'h19, 1, 1'b1);
    push(4'hE, 7'h79, 1, 1'b0);
    push(4'hD, 7'h24, 1, 1'b0);
    push(4'hB, 7'h30, 1, 1'b0);
    push(4'h7, 7'h19, 1, 1'b1);
    run(1);
    drive(16'h4321, 1'b0, 1'b0);
    run(7);

    total++;
    assert (q.size() == 0) else begin
      bad++;
      $error("FAIL queue_drain: observed size=%0d expected=0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
